// File: rtl/psys_route_pkg.sv
// Shared constants and types for the result-path width converters.
//
// Contents:
//   BEAT_W      narrow beat width (DMA side)
//   LANES       narrow beats per wide word
//   WIDE_W      wide word width (systolic array side)
//   CNT_W       width of a lane index
//   lane_last_t one last flag per lane of a wide word
package psys_route_pkg;

    localparam int BEAT_W = 128;
    localparam int LANES  = 12;
    localparam int WIDE_W = BEAT_W * LANES;
    localparam int CNT_W  = 4;

    typedef logic [LANES-1:0] lane_last_t;

endpackage

// File: rtl/in1536_out128_if.sv
// AXI-Stream bundle used on both sides of the width converter.
//
// Handshake: a transfer happens on every rising clock edge where tvalid and
// tready are both high. The master holds tdata/tlast/tvalid stable while
// tvalid is high and tready is low; tvalid may not drop before the transfer.
//
// Parameters:
//   DATA_W  tdata width
//   LAST_W  tlast width (one bit per lane on the wide side, one on the narrow)
// Modports:
//   master  drives tdata, tvalid, tlast; samples tready
//   slave   samples tdata, tvalid, tlast; drives tready
interface in1536_out128_if #(
    parameter int DATA_W = 128,
    parameter int LAST_W = 1
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic [LAST_W-1:0] tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/in1536_out128.sv
// Wide-to-narrow AXI-Stream converter: each accepted DW*LANES word is sent out
// as consecutive DW beats, lane 0 (bits [DW-1:0]) first. Lane i carries
// per-lane last bit i. With LAST_TRUNC set, the first lane whose last bit is
// set closes the word and the remaining lanes are dropped.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   s_axis  slave side, tdata DW*LANES bits, tlast LANES bits
//   m_axis  master side, tdata DW bits, tlast 1 bit
//
// The only combinational input-to-output path is m_axis.tready -> s_axis.tready,
// which lets a new word load on the same edge that the final beat leaves.
module in1536_out128 #(
    parameter int DW         = psys_route_pkg::BEAT_W,
    parameter int LANES      = psys_route_pkg::LANES,
    parameter int LAST_TRUNC = 0
) (
    input  logic             clk,
    input  logic             rst,
    in1536_out128_if.slave   s_axis,
    in1536_out128_if.master  m_axis
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
    localparam bit TRUNC = (LAST_TRUNC != 0);

    logic [DW*LANES-1:0] sbuf_q, sbuf_d;
    logic [LANES-1:0]    lbuf_q, lbuf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                full_q, full_d;

    logic end_beat;
    logic accept;
    logic out_hs;

    // The beat on the output is the final one of its word: either the last
    // lane, or (truncating) a lane carrying a set last bit.
    assign end_beat = full_q & ((cnt_q == LAST_LANE) | (TRUNC & lbuf_q[0]));

    assign s_axis.tready = ~full_q | (m_axis.tready & end_beat);
    assign accept        = s_axis.tvalid & s_axis.tready;
    assign out_hs        = full_q & m_axis.tready;

    assign m_axis.tdata  = sbuf_q[DW-1:0];
    assign m_axis.tlast  = lbuf_q[0];
    assign m_axis.tvalid = full_q;

    always_comb begin
        sbuf_d = sbuf_q;
        lbuf_d = lbuf_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (accept) begin
            // Loading wins over shifting; accept while full only happens on
            // the end beat, so nothing is lost.
            sbuf_d = s_axis.tdata;
            lbuf_d = s_axis.tlast;
            cnt_d  = '0;
            full_d = 1'b1;
        end else if (out_hs) begin
            if (end_beat) begin
                full_d = 1'b0;
                cnt_d  = '0;
            end else begin
                sbuf_d = sbuf_q >> DW;
                lbuf_d = lbuf_q >> 1;
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbuf_q <= '0;
            lbuf_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            sbuf_q <= sbuf_d;
            lbuf_q <= lbuf_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

endmodule
